// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared encodings and constants for the instruction fetch
// PC generator (FSM states, redirect kinds, chip-enable/branch/stall levels).
package pc_gen_pkg;

    localparam int unsigned STALL_W = 6;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // ce low, nothing issued
        ST_READY = 2'd1,  // ce high, no request outstanding
        ST_WAIT  = 2'd2   // request outstanding, waiting for ack
    } pc_state_e;

    // Kind of a redirect held in the pending buffer
    typedef enum logic {
        REDIR_BRANCH = 1'b0,
        REDIR_FLUSH  = 1'b1
    } redir_kind_e;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic Branch      = 1'b1;  // branch_flag_i level meaning "taken"
    localparam logic Stop        = 1'b1;  // stall bit level meaning "stalled"

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-side bundle of the PC generator.
//   master : pc_gen side (drives ce, if_req_o, if_addr_o, fetch_valid_o, fetch_pc_o)
//   slave  : pipeline control / instruction memory side
interface pc_gen_if
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);
    logic [STALL_W-1:0] stall;
    logic               branch_flag_i;
    logic [ADDR_W-1:0]  branch_target_i;
    logic               flush_i;
    logic [ADDR_W-1:0]  flush_pc_i;
    logic               ce;
    logic               if_req_o;
    logic [ADDR_W-1:0]  if_addr_o;
    logic               if_ack_i;
    logic               fetch_valid_o;
    logic [ADDR_W-1:0]  fetch_pc_o;

    modport master (
        input  stall, branch_flag_i, branch_target_i, flush_i, flush_pc_i, if_ack_i,
        output ce, if_req_o, if_addr_o, fetch_valid_o, fetch_pc_o
    );

    modport slave (
        output stall, branch_flag_i, branch_target_i, flush_i, flush_pc_i, if_ack_i,
        input  ce, if_req_o, if_addr_o, fetch_valid_o, fetch_pc_o
    );

endinterface

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: holds one redirect (branch or flush) that arrives while a
// fetch is outstanding, and merges it with the redirect of the current cycle.
//   clk, rst          : clock, synchronous active-high reset
//   branch_i/_target_i: branch taken this cycle and its target
//   flush_i/flush_pc_i: flush this cycle and its handler address
//   capture_i         : store the merged redirect (fetch outstanding, no ack)
//   clear_i           : drop the pending entry (it is applied this cycle)
//   eff_*_c           : merged redirect visible this cycle (combinational)
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned INST_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic              capture_i,
    input  logic              clear_i,
    output logic              eff_valid_c,
    output redir_kind_e       eff_kind_c,
    output logic [ADDR_W-1:0] eff_target_c
);

    // Redirect targets are forced onto an instruction boundary
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INST_BYTES - 1);

    logic              pend_valid_q;
    redir_kind_e       pend_kind_q;
    logic [ADDR_W-1:0] pend_target_q;

    logic              cur_valid;
    redir_kind_e       cur_kind;
    logic [ADDR_W-1:0] cur_target;
    logic              take_cur;

    // Merge: flush beats everything, a branch only replaces a pending branch
    always_comb begin
        cur_valid  = branch_i | flush_i;
        cur_kind   = flush_i ? REDIR_FLUSH : REDIR_BRANCH;
        cur_target = (flush_i ? flush_pc_i : branch_target_i) & ALIGN_MASK;
        take_cur   = cur_valid && (!pend_valid_q || (cur_kind == REDIR_FLUSH) ||
                                   (pend_kind_q == REDIR_BRANCH));
        eff_valid_c  = take_cur ? 1'b1       : pend_valid_q;
        eff_kind_c   = take_cur ? cur_kind   : pend_kind_q;
        eff_target_c = take_cur ? cur_target : pend_target_q;
    end

    // Pending entry
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            pend_valid_q  <= 1'b0;
            pend_kind_q   <= REDIR_BRANCH;
            pend_target_q <= '0;
        end else if (capture_i) begin
            pend_valid_q  <= eff_valid_c;
            pend_kind_q   <= eff_kind_c;
            pend_target_q <= eff_target_c;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: instruction fetch PC generator. Issues one fetch request at a time
// to instruction memory, advances the PC on each ack and applies branch /
// exception redirects (branch keeps the delay slot, flush squashes it).
//   clk, rst : clock, synchronous active-high reset
//   bus      : pc_gen_if.master -- stall vector, redirects, memory handshake
//              (ce, if_req_o, if_addr_o, if_ack_i) and fetch result
//              (fetch_valid_o, fetch_pc_o)
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'h0000_0000),
    parameter int unsigned       INST_BYTES   = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.master bus
);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic              req_q, req_d;
    logic              fvalid_q, fvalid_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;

    logic              ack_c;
    logic              stop_c;
    logic              branch_c;
    logic              in_wait_c;
    logic              squash_c;
    logic              eff_valid_c;
    redir_kind_e       eff_kind_c;
    logic [ADDR_W-1:0] eff_target_c;

    // Only the fetch-stage stall bit matters here
    logic unused_stall;
    assign unused_stall = ^bus.stall[STALL_W-1:1];

    assign ack_c     = bus.if_ack_i;
    assign stop_c    = (bus.stall[0] == Stop);
    assign branch_c  = (bus.branch_flag_i == Branch);
    assign in_wait_c = (state_q == ST_WAIT);
    // A flush seen while outstanding (pending) or on the ack cycle kills the fetch
    assign squash_c  = eff_valid_c && (eff_kind_c == REDIR_FLUSH);

    pc_redirect_buf #(
        .ADDR_W     (ADDR_W),
        .INST_BYTES (INST_BYTES)
    ) u_redirect_buf (
        .clk             (clk),
        .rst             (rst),
        .branch_i        (branch_c),
        .branch_target_i (bus.branch_target_i),
        .flush_i         (bus.flush_i),
        .flush_pc_i      (bus.flush_pc_i),
        .capture_i       (in_wait_c && !ack_c),
        .clear_i         (in_wait_c && ack_c),
        .eff_valid_c     (eff_valid_c),
        .eff_kind_c      (eff_kind_c),
        .eff_target_c    (eff_target_c)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_VECTOR;
            ce_q     <= ChipDisable;
            req_q    <= 1'b0;
            fvalid_q <= 1'b0;
            fpc_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ce_q     <= ce_d;
            req_q    <= req_d;
            fvalid_q <= fvalid_d;
            fpc_q    <= fpc_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_READY;
            ST_READY: state_d = stop_c ? ST_READY : ST_WAIT;
            ST_WAIT:  if (ack_c) state_d = stop_c ? ST_READY : ST_WAIT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output / pc datapath next values
    always_comb begin
        ce_d     = ChipEnable;
        req_d    = req_q;
        pc_d     = pc_q;
        fvalid_d = 1'b0;
        fpc_d    = fpc_q;
        case (state_q)
            ST_IDLE: begin
                req_d = 1'b0;
            end
            ST_READY: begin
                // No fetch in flight: a redirect just reloads the pc
                if (eff_valid_c) pc_d = eff_target_c;
                req_d = !stop_c;
            end
            ST_WAIT: begin
                req_d = 1'b1;
                if (ack_c) begin
                    fpc_d    = pc_q;
                    fvalid_d = !squash_c;
                    pc_d     = eff_valid_c ? eff_target_c : pc_q + ADDR_W'(INST_BYTES);
                    req_d    = !stop_c;
                end
            end
            default: begin
                ce_d  = ChipDisable;
                req_d = 1'b0;
            end
        endcase
    end

    assign bus.ce            = ce_q;
    assign bus.if_req_o      = req_q;
    assign bus.if_addr_o     = pc_q;
    assign bus.fetch_valid_o = fvalid_q;
    assign bus.fetch_pc_o    = fpc_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: self-checking bench for pc_gen. Per-cycle stimulus/expectation
// table plus hand-written wrap and mid-request reset sequences; delivered
// fetch addresses are tracked through a scoreboard queue.
module tb_pc_gen;

    localparam int unsigned AW = 32;

    logic clk = 1'b0;
    logic rst;

    pc_gen_if #(.ADDR_W(AW)) bus ();

    pc_gen #(
        .ADDR_W       (AW),
        .RESET_VECTOR (32'h0000_0000),
        .INST_BYTES   (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall0;
        logic        ack;
        logic        br;
        logic [31:0] br_t;
        logic        fl;
        logic [31:0] fl_t;
        logic        push;      // this cycle's ack must deliver push_pc
        logic [31:0] push_pc;
        logic        exp_ce;
        logic        exp_req;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          row      = 0;

    function automatic vec_t mk(input logic r, input logic s, input logic a,
                                input logic b, input logic [31:0] bt,
                                input logic f, input logic [31:0] ft,
                                input logic p, input logic [31:0] pp,
                                input logic ece, input logic ereq,
                                input logic [31:0] eaddr);
        vec_t v;
        v.rst = r; v.stall0 = s; v.ack = a;
        v.br = b; v.br_t = bt; v.fl = f; v.fl_t = ft;
        v.push = p; v.push_pc = pp;
        v.exp_ce = ece; v.exp_req = ereq; v.exp_addr = eaddr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got 0x%08h, required 0x%08h", name, row, act, exp);
        end
    endtask

    // Drive one cycle, then check outputs just after the rising edge
    task automatic apply(input vec_t t);
        logic        exp_v;
        logic [31:0] exp_pc;
        rst                 = t.rst;
        bus.stall           = {5'($urandom), t.stall0};
        bus.if_ack_i        = t.ack;
        bus.branch_flag_i   = t.br;
        bus.branch_target_i = t.br_t;
        bus.flush_i         = t.fl;
        bus.flush_pc_i      = t.fl_t;
        if (t.push) sb.push_back(t.push_pc);
        @(posedge clk);
        #1;
        check("ce", 32'(bus.ce), 32'(t.exp_ce));
        check("if_req", 32'(bus.if_req_o), 32'(t.exp_req));
        check("if_addr", bus.if_addr_o, t.exp_addr);
        exp_v = (sb.size() != 0);
        check("fetch_valid", 32'(bus.fetch_valid_o), 32'(exp_v));
        if (exp_v) begin
            exp_pc = sb.pop_front();
            if (bus.fetch_valid_o) check("fetch_pc", bus.fetch_pc_o, exp_pc);
        end
        row++;
    endtask

    initial begin
        rst = 1'b1;
        bus.stall = '0; bus.if_ack_i = 1'b0;
        bus.branch_flag_i = 1'b0; bus.branch_target_i = '0;
        bus.flush_i = 1'b0; bus.flush_pc_i = '0;

        //          rst s  a  br tgt       fl tgt       push pc            ce req addr
        // reset, come out of IDLE, sequential fetches 0x0, 0x4
        tbl.push_back(mk(1, 0, 0, 0, 0,         0, 0,          0, 0,          0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 0, 0,         0, 0,          0, 0,          0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0,         0, 0,          0, 0,          1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0,         0, 0,          0, 0,          1, 1, 32'h0));
        tbl.push_back(mk(0, 0, 1, 0, 0,         0, 0,          1, 32'h0,      1, 1, 32'h4));
        tbl.push_back(mk(0, 0, 1, 0, 0,         0, 0,          1, 32'h4,      1, 1, 32'h8));
        // branch during fetch of 0x8, ack 3 cycles later: delay slot kept
        tbl.push_back(mk(0, 0, 0, 1, 32'h100,   0, 0,          0, 0,          1, 1, 32'h8));
        tbl.push_back(mk(0, 0, 0, 0, 0,         0, 0,          0, 0,          1, 1, 32'h8));
        tbl.push_back(mk(0, 0, 0, 0, 0,         0, 0,          0, 0,          1, 1, 32'h8));
        tbl.push_back(mk(0, 0, 1, 0, 0,         0, 0,          1, 32'h8,      1, 1, 32'h100));
        // branch on the ack cycle itself: not squashed
        tbl.push_back(mk(0, 0, 1, 1, 32'h10,    0, 0,          1, 32'h100,    1, 1, 32'h10));
        // flush during fetch of 0x10: squashed, redirect to 0x180
        tbl.push_back(mk(0, 0, 0, 0, 0,         1, 32'h180,    0, 0,          1, 1, 32'h10));
        tbl.push_back(mk(0, 0, 1, 0, 0,         0, 0,          0, 0,          1, 1, 32'h180));
        // pending branch overwritten by flush; later branch dropped
        tbl.push_back(mk(0, 0, 0, 1, 32'h200,   0, 0,          0, 0,          1, 1, 32'h180));
        tbl.push_back(mk(0, 0, 0, 0, 0,         1, 32'h180,    0, 0,          1, 1, 32'h180));
        tbl.push_back(mk(0, 0, 0, 1, 32'h300,   0, 0,          0, 0,          1, 1, 32'h180));
        tbl.push_back(mk(0, 0, 1, 0, 0,         0, 0,          0, 0,          1, 1, 32'h180));
        tbl.push_back(mk(0, 0, 1, 0, 0,         0, 0,          1, 32'h180,    1, 1, 32'h184));
        // simultaneous flush and branch: flush wins; ack under stall -> READY
        tbl.push_back(mk(0, 0, 0, 1, 32'h80,    1, 32'h40,     0, 0,          1, 1, 32'h184));
        tbl.push_back(mk(0, 1, 1, 0, 0,         0, 0,          0, 0,          1, 0, 32'h40));
        // stall held 5 cycles in READY; stray ack ignored
        tbl.push_back(mk(0, 1, 0, 0, 0,         0, 0,          0, 0,          1, 0, 32'h40));
        tbl.push_back(mk(0, 1, 1, 0, 0,         0, 0,          0, 0,          1, 0, 32'h40));
        tbl.push_back(mk(0, 1, 0, 0, 0,         0, 0,          0, 0,          1, 0, 32'h40));
        tbl.push_back(mk(0, 1, 0, 0, 0,         0, 0,          0, 0,          1, 0, 32'h40));
        tbl.push_back(mk(0, 1, 0, 0, 0,         0, 0,          0, 0,          1, 0, 32'h40));
        // stall inside WAIT keeps the request up until ack
        tbl.push_back(mk(0, 0, 0, 0, 0,         0, 0,          0, 0,          1, 1, 32'h40));
        tbl.push_back(mk(0, 1, 0, 0, 0,         0, 0,          0, 0,          1, 1, 32'h40));
        tbl.push_back(mk(0, 1, 0, 0, 0,         0, 0,          0, 0,          1, 1, 32'h40));
        tbl.push_back(mk(0, 1, 1, 0, 0,         0, 0,          1, 32'h40,     1, 0, 32'h44));
        // redirect in READY loads pc directly, target aligned
        tbl.push_back(mk(0, 1, 0, 1, 32'h123,   0, 0,          0, 0,          1, 0, 32'h120));
        tbl.push_back(mk(0, 0, 0, 0, 0,         0, 0,          0, 0,          1, 1, 32'h120));
        // flush on the ack cycle squashes; aligned flush target
        tbl.push_back(mk(0, 0, 1, 0, 0,         1, 32'h3FF,    0, 0,          1, 1, 32'h3FC));
        tbl.push_back(mk(0, 0, 1, 0, 0,         0, 0,          1, 32'h3FC,    1, 1, 32'h400));

        foreach (tbl[i]) apply(tbl[i]);

        // PC wrap at the top of the address space
        apply(mk(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 1, 32'h400,       1, 1, 32'hFFFF_FFFC));
        apply(mk(0, 0, 1, 0, 0,             0, 0, 1, 32'hFFFF_FFFC, 1, 1, 32'h0));
        apply(mk(0, 0, 1, 0, 0,             0, 0, 1, 32'h0,         1, 1, 32'h4));
        apply(mk(0, 0, 1, 0, 0,             0, 0, 1, 32'h4,         1, 1, 32'h8));

        // Reset mid-request: request drops, late ack ignored, restart at vector
        apply(mk(1, 0, 0, 0, 0,             0, 0, 0, 0,             0, 0, 32'h0));
        check("rst_fetch_pc", bus.fetch_pc_o, 32'h0);
        apply(mk(0, 0, 1, 0, 0,             0, 0, 0, 0,             1, 0, 32'h0));
        apply(mk(0, 0, 0, 0, 0,             0, 0, 0, 0,             1, 1, 32'h0));
        apply(mk(0, 0, 1, 0, 0,             0, 0, 1, 32'h0,         1, 1, 32'h4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC and address width.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h00000000, first fetch address.
REQ-003 SHALL have parameter INST_BYTES, default 4, sequential PC increment; power of two.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 stall  input  6  pipeline stall vector; only bit 0 (fetch stage) is used.
REQ-007 branch_flag_i  input  1  branch taken; the instruction fetched in the same cycle is the delay slot and is kept.
REQ-008 branch_target_i  input  ADDR_W  branch target address.
REQ-009 flush_i  input  1  exception flush; kills the in-flight fetch.
REQ-010 flush_pc_i  input  ADDR_W  exception handler address.
REQ-011 ce  output  1  chip enable to instruction memory.
REQ-012 if_req_o  output  1  fetch request, registered.
REQ-013 if_addr_o  output  ADDR_W  fetch address; equals internal pc.
REQ-014 if_ack_i  input  1  single-cycle fetch acknowledge from memory.
REQ-015 fetch_valid_o  output  1  one-cycle pulse: the acknowledged instruction is valid for IF/ID.
REQ-016 fetch_pc_o  output  ADDR_W  address of the instruction flagged by fetch_valid_o.

Function
REQ-017 States SHALL be: IDLE (ce=0, no request), READY (ce=1, no request outstanding), WAIT (request outstanding).
REQ-018 IDLE->READY on the first clock with rst=0; ce SHALL rise at that edge.
REQ-019 READY with stall[0]=0: if_req_o<=1, go to WAIT; with stall[0]=1: stay in READY, pc held.
REQ-020 In WAIT, if_req_o and if_addr_o SHALL stay stable until if_ack_i, regardless of stall[0] or redirects.
REQ-021 On ack in WAIT: fetch_pc_o<=pc; fetch_valid_o<=1 unless the fetch is squashed; pc<=next pc (REQ-022).
REQ-022 Next pc SHALL be: pending/current flush target, else pending/current branch target, else pc+INST_BYTES (modulo 2^ADDR_W, wraps silently).
REQ-023 After an ack, if stall[0]=0, the unit SHALL issue the next request back-to-back (stay in WAIT, if_req_o=1 with the new address); otherwise go to READY with if_req_o=0.
REQ-024 Redirect in READY SHALL load pc directly at that edge; no squash.
REQ-025 Redirect in WAIT without ack SHALL be held in a pending register (valid, kind, target) and applied at ack.
REQ-026 Flush while a request is outstanding, or on the ack cycle itself, SHALL squash that fetch (fetch_valid_o=0).
REQ-027 Branch SHALL NOT squash.
REQ-028 Pending priority: a flush overwrites any pending entry; a branch overwrites only a pending branch; a branch arriving while a flush is pending is dropped.
REQ-029 Simultaneous flush_i and branch_flag_i: flush wins.
REQ-030 Redirect targets SHALL have bits [log2(INST_BYTES)-1:0] forced to 0.
REQ-031 Pending state SHALL clear when applied.
REQ-032 if_ack_i outside WAIT SHALL be ignored.
REQ-033 Fetch latency from request to fetch_valid_o SHALL be ack cycle + 1.

Reset
REQ-034 rst SHALL force: state=IDLE, pc=RESET_VECTOR, ce=0, if_req_o=0, fetch_valid_o=0, fetch_pc_o=0, pending cleared.
REQ-035 Reset mid-request SHALL drop if_req_o at that edge; acks arriving afterward SHALL be ignored.

Structure
REQ-036 State encoding, redirect-kind encoding and the ChipEnable/ChipDisable, Branch and Stop constants SHALL live in the shared defines package.
REQ-037 The pending redirect register and its priority logic SHALL be one sub-module, pc_redirect_buf; the FSM and pc datapath remain in pc_gen.

Verification
REQ-038 Reset, then ack each request on the next cycle -> if_addr_o sequence 0x0, 0x4, 0x8; fetch_valid_o pulses with fetch_pc_o 0x0, 0x4, 0x8.
REQ-039 Branch to 0x100 asserted during an outstanding fetch of 0x8, ack 3 cycles later -> 0x8 delivered valid (delay slot); next if_addr_o=0x100.
REQ-040 Flush to 0x180 during an outstanding fetch of 0x10 -> 0x10 ack produces no fetch_valid_o; next if_addr_o=0x180.
REQ-041 Branch 0x200 pending, then flush 0x180 before ack -> next pc 0x180; a later branch before the ack is dropped.
REQ-042 stall[0]=1 held for 5 cycles in READY -> no request issued, pc unchanged; stall during WAIT keeps if_req_o high until ack.
REQ-043 Two cases -> pc=0xFFFFFFFC advancing wraps to 0x0; rst pulse mid-request drops if_req_o and restarts at RESET_VECTOR.
